// File: rtl/controlador_prueba_mfd.sv
// Purpose: drives the 16 ABCD vectors into a two-output circuit under test and
//          compares {f1,f2} with a programmable expected table.
// Latency: done pulses 16*(SETTLE+2) edges after the edge that accepts start.
// Backpressure: none; start and table writes are ignored while busy.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 sweep request, accepted only in IDLE
//   tbl_we/addr/data      expected-table write port (addr = ABCD, data = {F1,F2})
//   f1, f2                responses of the circuit under test
//   abcd                  registered stimulus vector
//   busy, done, pass      status: not-IDLE, end-of-sweep pulse, zero-mismatch flag
//   err_count             mismatches in the current/last sweep (0..16)
//   first_err(_valid)     index of the first mismatching vector
module controlador_prueba_mfd #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       tbl_we,
  input  logic [3:0] tbl_addr,
  input  logic [1:0] tbl_data,
  input  logic       f1,
  input  logic       f2,
  output logic [3:0] abcd,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_err,
  output logic       first_err_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_FIN
  } state_t;

  // WAIT counts down from SETTLE-1 to 0, giving exactly SETTLE cycles
  localparam logic [3:0] LP_SETTLE_M1 = 4'(SETTLE - 1);

  state_t     r_state;
  logic [3:0] r_idx;
  logic [3:0] r_settle;
  logic [1:0] r_tbl [16];

  logic       w_mismatch;
  logic [4:0] w_err_next;

  assign w_mismatch = ({f1, f2} != r_tbl[r_idx]);
  // 16 vectors at most one miss each: 5 bits never wrap
  assign w_err_next = err_count + 5'(w_mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_idx           <= '0;
      r_settle        <= '0;
      abcd            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err       <= '0;
      first_err_valid <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_tbl[i] <= 2'b00;
      end
    end else begin
      done <= 1'b0;

      // Table is writable only while idle; a write on the same edge as an
      // accepted start still lands before its vector is checked.
      if (tbl_we && (r_state == S_IDLE)) begin
        r_tbl[tbl_addr] <= tbl_data;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state         <= S_APPLY;
            r_idx           <= '0;
            abcd            <= '0;
            err_count       <= '0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
            busy            <= 1'b1;
          end
        end

        S_APPLY: begin
          abcd     <= r_idx;
          r_settle <= LP_SETTLE_M1;
          r_state  <= S_WAIT;
        end

        S_WAIT: begin
          if (r_settle == 4'd0) begin
            r_state <= S_CHECK;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end

        S_CHECK: begin
          if (w_mismatch) begin
            err_count <= w_err_next;
            if (!first_err_valid) begin
              first_err       <= r_idx;
              first_err_valid <= 1'b1;
            end
          end
          if (r_idx == 4'd15) begin
            // pass must include this last comparison, hence w_err_next
            r_state <= S_FIN;
            done    <= 1'b1;
            pass    <= (w_err_next == 5'd0);
          end else begin
            r_idx   <= r_idx + 4'd1;
            abcd    <= r_idx + 4'd1;
            r_state <= S_APPLY;
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/controlador_prueba_mfd.md
CONTROLADOR_PRUEBA_MFD -- requirements
Module: controlador_prueba_mfd

Interface
REQ-001 Parameter SETTLE, default 1, range 1..15: number of WAIT cycles between applying a vector and sampling f1/f2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a full 16-vector sweep; sampled only in IDLE.
REQ-005 tbl_we  input  1  expected-table write enable.
REQ-006 tbl_addr  input  4  expected-table write address (= ABCD vector).
REQ-007 tbl_data  input  2  expected value: bit1 = F1, bit0 = F2.
REQ-008 f1  input  1  F1 response of the circuit under test.
REQ-009 f2  input  1  F2 response of the circuit under test.
REQ-010 abcd  output  4  registered stimulus: abcd[3]=A, abcd[2]=B, abcd[1]=C, abcd[0]=D.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at end of sweep.
REQ-013 pass  output  1  high after a sweep with zero mismatches; held until next accepted start.
REQ-014 err_count  output  5  mismatch count of the current or last sweep, 0..16.
REQ-015 first_err  output  4  vector index of the first mismatch.
REQ-016 first_err_valid  output  1  high once a mismatch has been recorded in the current or last sweep.

Function
REQ-017 Table: 16 x 2-bit registers; written at clock edge when tbl_we=1 and busy=0; writes while busy=1 are ignored.
REQ-018 FSM states IDLE, APPLY, WAIT, CHECK, FIN; internal 4-bit vector index idx and settle counter.
REQ-019 IDLE: start=1 -> APPLY; same edge sets idx=0, abcd=0, err_count=0, first_err=0, first_err_valid=0, pass=0.
REQ-020 APPLY: exactly 1 cycle, abcd = idx; -> WAIT with settle counter loaded.
REQ-021 WAIT: exactly SETTLE cycles, abcd held; -> CHECK.
REQ-022 CHECK: exactly 1 cycle; compares {f1,f2} with table[idx]; mismatch increments err_count at the exiting edge.
REQ-023 CHECK: on mismatch with first_err_valid=0, same edge sets first_err=idx and first_err_valid=1; later mismatches do not change first_err.
REQ-024 CHECK: idx<15 -> APPLY with idx+1 and abcd=idx+1; idx=15 -> FIN.
REQ-025 FIN: exactly 1 cycle, done=1; pass set to (err_count==0) including the final CHECK result; -> IDLE.
REQ-026 Latency: done is high in the cycle beginning 16*(SETTLE+2) edges after the edge that sampled start (48 edges for SETTLE=1).
REQ-027 start while busy=1 is ignored; no restart, no queuing. start=1 held continuously restarts a sweep on the edge after FIN.
REQ-028 Simultaneous start and tbl_we in IDLE: both take effect on the same edge; the written entry is used by its CHECK.
REQ-029 err_count does not wrap: maximum 16 when all vectors mismatch.
REQ-030 After a sweep: abcd holds 15; err_count, first_err, first_err_valid and pass hold until the next accepted start.

Reset
REQ-031 rst_n=0 immediately, regardless of clock, forces: state IDLE, idx=0, abcd=0, busy=0, done=0, pass=0, err_count=0, first_err=0, first_err_valid=0, all table entries 2'b00.
REQ-032 Reset during a sweep aborts it: no done pulse; outputs as in REQ-031; first start after rst_n rises begins a fresh sweep from vector 0.

Verification
REQ-033 Table loaded with the correct F1F2 for all 16 vectors, SETTLE=1, start pulse -> abcd steps 0..15, done at edge 48, pass=1, err_count=0, first_err_valid=0.
REQ-034 Table entries 5 and 12 corrupted, then start -> err_count=2, first_err=5, first_err_valid=1, pass=0.
REQ-035 All entries wrong (each inverted) -> err_count=16, first_err=0, pass=0; no wrap to 0.
REQ-036 start pulses and tbl_we writes to entry 3 issued mid-sweep -> ignored; table[3] unchanged; single done at edge 48.
REQ-037 rst_n=0 during vector 7 -> all outputs 0 asynchronously; no done; next start -> full sweep from abcd=0.
REQ-038 SETTLE=3 -> done at edge 80; each abcd value held for 5 cycles.
